// File: rtl/tiny85_uart_rx.sv
// tiny85_uart_rx: 8N1 UART receiver for the ATtiny85 PB1 line with a valid/ready holding register.
// Ports: clk, rst_n (sync, active-low), rx (async serial line, idle high),
//   rx_data/rx_valid/rx_ready (holding register handshake), frame_err and overrun (one-cycle pulses).
module tiny85_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t r_state, w_state;
  logic r_s1, r_s2, r_sd;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0] r_idx, w_idx;
  logic [7:0] r_shift, w_shift, w_data;
  logic w_valid, w_ferr, w_ovr;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + 1'b1;
    w_idx = r_idx;
    w_shift = r_shift;
    w_data = rx_data;
    w_valid = rx_valid & ~rx_ready;
    w_ferr = 1'b0;
    w_ovr = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        w_state = (~r_s2 & r_sd) ? START : IDLE;
      end
      START: if (r_cnt == HALF) begin
        w_cnt = '0;
        w_idx = '0;
        w_state = r_s2 ? IDLE : DATA;
      end
      DATA: if (r_cnt == FULL) begin
        w_cnt = '0;
        w_shift[r_idx] = r_s2;
        w_idx = r_idx + 3'd1;
        w_state = (r_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (r_cnt == FULL) begin
        w_cnt = '0;
        w_state = r_s2 ? IDLE : BREAK;
        w_ferr = ~r_s2;
        // a consumer taking the old byte on this very edge frees the register for the new one
        if (r_s2 && (~rx_valid || rx_ready)) begin
          w_data = r_shift;
          w_valid = 1'b1;
        end else if (r_s2) begin
          w_ovr = 1'b1;
        end
      end
      BREAK: begin
        w_cnt = '0;
        w_state = r_s2 ? IDLE : BREAK;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_sd <= 1'b1;
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
      r_sd <= r_s2;
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_idx <= w_idx;
      r_shift <= w_shift;
      rx_data <= w_data;
      rx_valid <= w_valid;
      frame_err <= w_ferr;
      overrun <= w_ovr;
    end
  end
endmodule
